matrix_uart_printer: RTL and testbench

- Transmit-side formatter for matrix results: serialises a packed matrix from `matrix_calculator` into ASCII decimal text.
- Drives the existing `uart_tx` byte handshake (`tx_data`/`tx_start`/`tx_busy`).
- Counterpart of the receive-side parser in `matrix_io_ctrl`. Lets a result be printed without the IO controller formatting it byte by byte.

---
 rtl/matrix_uart_printer.sv | 242 ++++++++++++++++++++++++
 tb/tb_matrix_uart_printer.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/matrix_uart_printer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : matrix_uart_printer
// Purpose  : Prints a packed row-major matrix as ASCII decimal text through
//            the uart_tx byte handshake (space-separated, CR LF per row).
// Revision : 1.0 - initial release
// ============================================================================
module matrix_uart_printer #(
    parameter int MAX_DIM = 5,
    parameter int ELEM_W  = 16,
    parameter int SIGNED  = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic [5:0]                          dim,
    input  logic [MAX_DIM*MAX_DIM*ELEM_W-1:0]   data,
    output logic                                busy,
    output logic                                done,
    output logic                                error,
    output logic [7:0]                          tx_data,
    output logic                                tx_start,
    input  logic                                tx_busy
);

    localparam int c_n_elem = MAX_DIM * MAX_DIM;
    localparam int c_idx_w  = $clog2(c_n_elem);
    localparam int c_mag_w  = ELEM_W + 1;
    localparam int c_data_w = c_n_elem * ELEM_W;

    localparam logic [2:0]         c_max_dim = 3'(MAX_DIM);
    localparam logic [c_idx_w-1:0] c_idx_one = c_idx_w'(1);
    localparam logic [2:0]         c_last_dg = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD   = 4'd1,
        S_SIGN   = 4'd2,
        S_CONV   = 4'd3,
        S_EMIT   = 4'd4,
        S_SEP    = 4'd5,
        S_CR     = 4'd6,
        S_LF     = 4'd7,
        S_FINISH = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        PH_WAIT  = 2'd0,
        PH_FIRE  = 2'd1,
        PH_GUARD = 2'd2
    } phase_t;

    state_t r_state, w_state_nxt;
    phase_t r_phase, w_phase_nxt;

    logic [2:0]          r_rows, r_cols, r_row, r_col;
    logic [c_data_w-1:0] r_data;
    logic [c_idx_w-1:0]  r_idx;
    logic                r_neg, r_seen, r_err;
    logic [c_mag_w-1:0]  r_mag;
    logic [2:0]          r_pidx, r_eidx;
    logic [3:0]          r_cnt;
    logic [3:0]          r_digits [5];
    logic [7:0]          r_tx_data;

    logic [ELEM_W-1:0]   w_elems [c_n_elem];
    logic [ELEM_W-1:0]   w_elem;
    logic [c_mag_w-1:0]  w_sext, w_pow;
    logic                w_dim_bad, w_is_neg, w_ge, w_last_col, w_last_row;
    logic                w_skip, w_byte_req, w_load_tx, w_byte_done;
    logic [7:0]          w_byte;

    for (genvar g = 0; g < c_n_elem; g++) begin : g_unpack
        assign w_elems[g] = r_data[g*ELEM_W +: ELEM_W];
    end

    assign w_dim_bad  = (dim[5:3] == 3'd0) || (dim[2:0] == 3'd0) ||
                        (dim[5:3] > c_max_dim) || (dim[2:0] > c_max_dim);
    assign w_elem     = w_elems[r_idx];
    assign w_is_neg   = (SIGNED != 0) && w_elem[ELEM_W-1];
    assign w_sext     = {w_elem[ELEM_W-1], w_elem};
    assign w_ge       = (r_mag >= w_pow);
    assign w_last_col = (r_col == r_cols - 3'd1);
    assign w_last_row = (r_row == r_rows - 3'd1);
    // Leading zeros are dropped, but the units digit is always printed.
    assign w_skip     = (r_state == S_EMIT) && !r_seen &&
                        (r_digits[r_eidx] == 4'd0) && (r_eidx != c_last_dg);

    always_comb begin
        case (r_pidx)
            3'd0:    w_pow = c_mag_w'(10000);
            3'd1:    w_pow = c_mag_w'(1000);
            3'd2:    w_pow = c_mag_w'(100);
            3'd3:    w_pow = c_mag_w'(10);
            default: w_pow = c_mag_w'(1);
        endcase
    end

    always_comb begin
        w_byte     = 8'h00;
        w_byte_req = 1'b0;
        case (r_state)
            S_SIGN: begin w_byte = 8'h2D; w_byte_req = r_neg; end
            S_EMIT: begin w_byte = 8'h30 + {4'h0, r_digits[r_eidx]}; w_byte_req = !w_skip; end
            S_SEP:  begin w_byte = 8'h20; w_byte_req = 1'b1; end
            S_CR:   begin w_byte = 8'h0D; w_byte_req = 1'b1; end
            S_LF:   begin w_byte = 8'h0A; w_byte_req = 1'b1; end
            default: ;
        endcase
    end

    // Byte handshake: wait idle -> one tx_start cycle -> one blind guard cycle.
    always_comb begin
        w_phase_nxt = r_phase;
        w_load_tx   = 1'b0;
        w_byte_done = 1'b0;
        case (r_phase)
            PH_WAIT: begin
                if (w_byte_req && !tx_busy) begin
                    w_phase_nxt = PH_FIRE;
                    w_load_tx   = 1'b1;
                end
            end
            PH_FIRE:  w_phase_nxt = PH_GUARD;
            PH_GUARD: begin
                w_phase_nxt = PH_WAIT;
                w_byte_done = 1'b1;
            end
            default:  w_phase_nxt = PH_WAIT;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (start) w_state_nxt = w_dim_bad ? S_FINISH : S_LOAD;
            S_LOAD:   w_state_nxt = S_SIGN;
            S_SIGN:   if (!r_neg || w_byte_done) w_state_nxt = S_CONV;
            S_CONV:   if (!w_ge && r_pidx == c_last_dg) w_state_nxt = S_EMIT;
            S_EMIT:   if (w_byte_done && r_eidx == c_last_dg)
                          w_state_nxt = w_last_col ? S_CR : S_SEP;
            S_SEP:    if (w_byte_done) w_state_nxt = S_LOAD;
            S_CR:     if (w_byte_done) w_state_nxt = S_LF;
            S_LF:     if (w_byte_done) w_state_nxt = w_last_row ? S_FINISH : S_LOAD;
            S_FINISH: w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_phase <= PH_WAIT;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rows    <= 3'd0;
            r_cols    <= 3'd0;
            r_row     <= 3'd0;
            r_col     <= 3'd0;
            r_data    <= '0;
            r_idx     <= '0;
            r_neg     <= 1'b0;
            r_seen    <= 1'b0;
            r_err     <= 1'b0;
            r_mag     <= '0;
            r_pidx    <= 3'd0;
            r_eidx    <= 3'd0;
            r_cnt     <= 4'd0;
            r_tx_data <= 8'h00;
            for (int i = 0; i < 5; i++) r_digits[i] <= 4'd0;
        end else begin
            if (w_load_tx) r_tx_data <= w_byte;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_rows <= dim[5:3];
                        r_cols <= dim[2:0];
                        r_data <= data;
                        r_err  <= w_dim_bad;
                        r_row  <= 3'd0;
                        r_col  <= 3'd0;
                        r_idx  <= '0;
                    end
                end
                S_LOAD: begin
                    r_neg  <= w_is_neg;
                    r_mag  <= w_is_neg ? -w_sext : {1'b0, w_elem};
                    r_pidx <= 3'd0;
                    r_cnt  <= 4'd0;
                    r_eidx <= 3'd0;
                    r_seen <= 1'b0;
                end
                S_CONV: begin
                    if (w_ge) begin
                        r_mag <= r_mag - w_pow;
                        r_cnt <= r_cnt + 4'd1;
                    end else begin
                        r_digits[r_pidx] <= r_cnt;
                        r_cnt            <= 4'd0;
                        r_pidx           <= r_pidx + 3'd1;
                    end
                end
                S_EMIT: begin
                    if (w_skip) r_eidx <= r_eidx + 3'd1;
                    if (w_byte_done) begin
                        r_seen <= 1'b1;
                        r_eidx <= r_eidx + 3'd1;
                    end
                end
                S_SEP: begin
                    if (w_byte_done) begin
                        r_col <= r_col + 3'd1;
                        r_idx <= r_idx + c_idx_one;
                    end
                end
                S_LF: begin
                    if (w_byte_done) begin
                        r_col <= 3'd0;
                        r_row <= r_row + 3'd1;
                        r_idx <= r_idx + c_idx_one;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy     = (r_state != S_IDLE) && (r_state != S_FINISH);
    assign done     = (r_state == S_FINISH);
    assign error    = (r_state == S_FINISH) && r_err;
    assign tx_start = (r_phase == PH_FIRE);
    assign tx_data  = r_tx_data;

endmodule
`default_nettype wire

// File: tb/tb_matrix_uart_printer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_matrix_uart_printer
// Purpose  : Bench for matrix_uart_printer; signed and unsigned instances run
//            side by side against a string-formatting reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matrix_uart_printer;

    typedef logic [7:0] bq_t [$];

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [5:0]   dim;
    logic [399:0] data;
    logic [1:0]   busy, done, error, tx_start, tx_busy;
    logic [7:0]   tx_data [2];

    int  n_tests = 0;
    int  n_fail  = 0;
    int  n_tx [2];
    int  done_cnt [2];
    int  bcnt [2];
    bit  hold = 1'b0;
    bit  exp_err = 1'b0;
    logic [7:0] exp_q [2][$];

    always #5 clk = ~clk;

    matrix_uart_printer #(.MAX_DIM(5), .ELEM_W(16), .SIGNED(1)) u_dut_s (
        .clk(clk), .rst_n(rst_n), .start(start), .dim(dim), .data(data),
        .busy(busy[0]), .done(done[0]), .error(error[0]),
        .tx_data(tx_data[0]), .tx_start(tx_start[0]), .tx_busy(tx_busy[0])
    );

    matrix_uart_printer #(.MAX_DIM(5), .ELEM_W(16), .SIGNED(0)) u_dut_u (
        .clk(clk), .rst_n(rst_n), .start(start), .dim(dim), .data(data),
        .busy(busy[1]), .done(done[1]), .error(error[1]),
        .tx_data(tx_data[1]), .tx_start(tx_start[1]), .tx_busy(tx_busy[1])
    );

    // uart_tx stand-in: busy from the cycle after tx_start for 10 cycles
    always @(posedge clk or negedge rst_n) begin
        for (int k = 0; k < 2; k++) begin
            if (!rst_n)           bcnt[k] <= 0;
            else if (tx_start[k]) bcnt[k] <= 10;
            else if (bcnt[k] > 0) bcnt[k] <= bcnt[k] - 1;
        end
    end
    assign tx_busy[0] = hold || (bcnt[0] != 0);
    assign tx_busy[1] = hold || (bcnt[1] != 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: decimal text of each element, space between columns, CR LF per row.
    function automatic void model_bytes(input logic [5:0] d, input logic [399:0] dat,
                                        input bit sgn, output bq_t q);
        int rows, cols;
        logic [15:0] v;
        string s;
        rows = int'(d[5:3]);
        cols = int'(d[2:0]);
        q = {};
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                v = dat[16*(r*cols+c) +: 16];
                if (sgn && v[15]) s = $sformatf("-%0d", 65536 - int'(v));
                else              s = $sformatf("%0d", int'(v));
                for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
                if (c == cols - 1) begin
                    q.push_back(8'h0D);
                    q.push_back(8'h0A);
                end else begin
                    q.push_back(8'h20);
                end
            end
        end
    endfunction

    function automatic bit same_q(input bq_t a, input bq_t b);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
        return 1'b1;
    endfunction

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 2; k++) begin
                if (tx_start[k]) begin
                    n_tx[k]++;
                    check("tx_start while uart busy", 32'(tx_busy[k]), 32'd0);
                    if (exp_q[k].size() == 0) check("byte count overrun", 32'(n_tx[k]), 32'd0);
                    else                      check("tx_data", 32'(tx_data[k]), 32'(exp_q[k].pop_front()));
                end
                if (done[k]) begin
                    done_cnt[k]++;
                    check("error at done", 32'(error[k]), 32'(exp_err));
                    check("busy at done", 32'(busy[k]), 32'd0);
                    check("bytes missing at done", 32'(exp_q[k].size()), 32'd0);
                end
                if (error[k] && !done[k]) check("error without done", 32'(error[k]), 32'd0);
                if (exp_err && busy[k]) check("busy on invalid dim", 32'(busy[k]), 32'd0);
            end
        end
    end

    task automatic prep(input logic [5:0] d, input logic [399:0] dat, input bit bad);
        bq_t q;
        exp_err = bad;
        for (int k = 0; k < 2; k++) begin
            if (bad) q = {};
            else     model_bytes(d, dat, (k == 0), q);
            exp_q[k]    = q;
            n_tx[k]     = 0;
            done_cnt[k] = 0;
        end
    endtask

    task automatic pulse_start(input logic [5:0] d, input logic [399:0] dat);
        @(negedge clk);
        dim = d; data = dat; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int i;
        for (i = 0; i < budget && !(done_cnt[0] > 0 && done_cnt[1] > 0); i++) @(negedge clk);
        if (i >= budget) check("done timeout", 32'(done_cnt[0] + done_cnt[1]), 32'd2);
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("done pulse count", 32'(done_cnt[k]), 32'd1);
            check("bytes left", 32'(exp_q[k].size()), 32'd0);
            check("busy after done", 32'(busy[k]), 32'd0);
        end
    endtask

    task automatic run_valid(input logic [5:0] d, input logic [399:0] dat);
        prep(d, dat, 1'b0);
        pulse_start(d, dat);
        check("busy after start s", 32'(busy[0]), 32'd1);
        check("busy after start u", 32'(busy[1]), 32'd1);
        wait_done(20000);
    endtask

    task automatic run_invalid(input logic [5:0] d);
        prep(d, data, 1'b1);
        pulse_start(d, data);
        for (int k = 0; k < 2; k++) begin
            check("invalid done", 32'(done[k]), 32'd1);
            check("invalid error", 32'(error[k]), 32'd1);
            check("invalid busy", 32'(busy[k]), 32'd0);
        end
        repeat (5) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("invalid done count", 32'(done_cnt[k]), 32'd1);
            check("invalid tx count", 32'(n_tx[k]), 32'd0);
        end
    endtask

    logic [399:0] d1, d2, d3, d5, d_alt;
    bq_t q, lit;

    initial begin
        rst_n = 1'b0; start = 1'b0; dim = '0; data = '0;
        d1 = '0; d1[15:0] = 16'd1; d1[31:16] = 16'd2; d1[47:32] = 16'd3; d1[63:48] = 16'd4;
        d2 = '0; d2[15:0] = 16'hFFFB; d2[31:16] = 16'h8000; d2[47:32] = 16'h0000;
        d3 = '0; d3[15:0] = 16'hFFFF; d3[31:16] = 16'd100;
        d5 = '0; d5[15:0] = 16'd7; d5[31:16] = 16'hFFF4; d5[47:32] = 16'd300; d5[63:48] = 16'd0;
        d_alt = '1;

        // pin the model against hand-derived byte streams
        model_bytes(6'b010_010, d1, 1'b1, q);
        lit = '{8'h31, 8'h20, 8'h32, 8'h0D, 8'h0A, 8'h33, 8'h20, 8'h34, 8'h0D, 8'h0A};
        check("model 2x2", 32'(same_q(q, lit)), 32'd1);
        model_bytes(6'b001_011, d2, 1'b1, q);
        lit = '{8'h2D, 8'h35, 8'h20, 8'h2D, 8'h33, 8'h32, 8'h37, 8'h36, 8'h38, 8'h20, 8'h30, 8'h0D, 8'h0A};
        check("model signed", 32'(same_q(q, lit)), 32'd1);
        model_bytes(6'b001_010, d3, 1'b0, q);
        lit = '{8'h36, 8'h35, 8'h35, 8'h33, 8'h35, 8'h20, 8'h31, 8'h30, 8'h30, 8'h0D, 8'h0A};
        check("model unsigned", 32'(same_q(q, lit)), 32'd1);

        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("reset busy", 32'(busy[k]), 32'd0);
            check("reset done", 32'(done[k]), 32'd0);
            check("reset error", 32'(error[k]), 32'd0);
            check("reset tx_start", 32'(tx_start[k]), 32'd0);
            check("reset tx_data", 32'(tx_data[k]), 32'd0);
        end
        rst_n = 1'b1;

        run_valid(6'b010_010, d1);
        run_valid(6'b001_011, d2);
        run_valid(6'b001_010, d3);
        run_invalid(6'b110_001);
        run_invalid(6'b000_011);
        run_invalid(6'b001_110);

        // stalled uart: exactly one byte while held, re-start ignored
        prep(6'b010_010, d5, 1'b0);
        pulse_start(6'b010_010, d5);
        for (int i = 0; i < 1000 && n_tx[0] < 1; i++) @(negedge clk);
        hold = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (i == 100) begin dim = 6'b001_001; data = d_alt; start = 1'b1; end
            if (i == 101) start = 1'b0;
        end
        check("stall tx count s", 32'(n_tx[0]), 32'd1);
        check("stall tx count u", 32'(n_tx[1]), 32'd1);
        check("stall busy s", 32'(busy[0]), 32'd1);
        check("stall busy u", 32'(busy[1]), 32'd1);
        hold = 1'b0;
        wait_done(20000);

        // reset after the third byte, then a clean reprint
        prep(6'b010_010, d1, 1'b0);
        pulse_start(6'b010_010, d1);
        for (int i = 0; i < 2000 && n_tx[0] < 3; i++) @(negedge clk);
        check("bytes before reset", 32'(n_tx[0]), 32'd3);
        rst_n = 1'b0;
        exp_q[0] = {};
        exp_q[1] = {};
        repeat (2) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            check("in reset tx_start", 32'(tx_start[k]), 32'd0);
            check("in reset busy", 32'(busy[k]), 32'd0);
            check("in reset done", 32'(done[k]), 32'd0);
        end
        rst_n = 1'b1;
        run_valid(6'b010_010, d1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
